hart_seq: RTL and testbench
===========================

Name: hart_seq

Overview:
Multi-cycle sequencer wrapping the single-cycle hart core; it owns the PC register and latched instruction.
- Shares one memory bus port between instruction fetch and load/store.
- Performs byte-lane steering for stores and alignment plus sign/zero-extension for loads.
- Qualifies the hart's register-file write with a one-cycle commit pulse.
- Sits between the hart and the system memory bus.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc  out  32  current PC to hart
insn  out  32  latched instruction to hart
nextpc  in  32  hart's computed next PC
memaddr  in  32  hart data address
memwdata  in  32  hart store data (low bytes significant)
memw  in  1  hart store request
memr  in  1  hart load request (rwsel==1, exported by hart)
memsext  in  1  load sign-extend
memwidth  in  2  0=byte, 1=half, 2=word, 3=illegal
memrdata  out  32  aligned/extended load data to hart
hart_commit  out  1  one-cycle pulse; hart regfile we3 = regw & hart_commit
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  out  32  lane-steered write data
bus_be  out  4  byte enables
bus_ready  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data
fault  out  1  sticky fault
fault_cause  out  2  01 misaligned data, 10 misaligned nextpc, 11 illegal width
fault_pc  out  32  PC of faulting instruction

Behaviour:
- Reset (synchronous, priority over everything, including mid-transaction):
  - pc<=RESET_PC; insn<=32'h0000_0013 (NOP); memrdata<=0.
  - bus_req, bus_we, bus_be, hart_commit, fault, fault_cause, fault_pc all 0.
  - state<=IFETCH.
  - Any outstanding bus response after reset is ignored until the next request is accepted.
- States: IFETCH, IWAIT, EXEC, DREQ, DWAIT, COMMIT, FAULT.
- IFETCH: bus_req=1, bus_we=0, bus_addr=pc, bus_be=4'hF. bus_ready=1 -> IWAIT.
- IWAIT: bus_rvalid=1 -> insn<=bus_rdata, go to EXEC. rvalid never arrives in the same cycle as ready.
- EXEC: one settle cycle for hart combinational logic; checks in priority order:
  1. memr|memw with memwidth==3 -> FAULT, cause 11.
  2. memr|memw with misaligned address (half & addr[0]; word & addr[1:0]!=0) -> FAULT, cause 01.
  3. nextpc[1:0]!=0 -> FAULT, cause 10.
  4. memr|memw -> DREQ; otherwise -> COMMIT.
  - memr and memw both set: treat as store.
- DREQ: bus_req=1; bus_addr, bus_we, bus_be, bus_wdata held stable until bus_ready.
  - Store lanes: byte -> wdata={4{memwdata[7:0]}}, be=4'b0001<<addr[1:0]; half -> wdata={2{memwdata[15:0]}}, be=4'b0011<<addr[1:0]; word -> be=4'hF.
  - Load: be=4'hF.
  - On ready: store -> COMMIT; load -> DWAIT. Stores produce no rvalid.
- DWAIT: on bus_rvalid, memrdata<=extract(bus_rdata), go to COMMIT.
  - extract: shift right by 8*addr[1:0], then truncate to width.
  - sign-extend if memsext, else zero-extend; word passes through.
- COMMIT: hart_commit=1 for exactly this cycle; pc<=nextpc at end of cycle -> IFETCH.
- FAULT: terminal until reset.
  - fault=1; fault_pc=pc of the faulting instruction.
  - bus_req=0, hart_commit never asserted.
- bus_req is 0 in IWAIT, EXEC, DWAIT, COMMIT, FAULT. bus_rvalid outside IWAIT/DWAIT is ignored.
- Latency with zero-wait bus (ready in request cycle, rvalid next cycle):
  - ALU/branch/jump: 4 cycles.
  - Store: 5 cycles.
  - Load: 6 cycles.
- memrdata holds its last loaded value until the next load completes.
- pc wraps modulo 2^32.

Test Plan:
- Reset, zero-wait memory with addi x1,x0,5 at 0 -> first bus_req cycle after reset has bus_addr=0; hart_commit pulses on cycle 4; pc=4; next fetch bus_addr=4.
- sb from x2=0x000000AB to addr 0x103 -> bus_we=1, bus_addr=0x100, bus_be=4'b1000, bus_wdata=0xABABABAB; commit 5 cycles after fetch start.
- lb/lbu at 0x102 with memory word 0x1280FF00 -> memrdata=0xFFFFFF80 (lb), 0x00000080 (lbu) during the COMMIT pulse.
- Bus with 3-cycle ready stall and 2-cycle rvalid delay on lw -> bus_addr/bus_be stable through the stall; single commit pulse; loaded word correct; no duplicate request.
- lw at 0x102 -> fault=1, cause=01, fault_pc=the lw PC, no commit, bus_req stays 0. A following reset clears the fault and fetches from RESET_PC.
- Reset asserted in DWAIT while a late rvalid arrives -> rvalid is ignored; pc=RESET_PC; insn=NOP; next fetch is from RESET_PC.

Source files
------------

// File: rtl/hart_seq_if.sv
// Memory bus between the hart sequencer (master) and system memory (slave).
// One request/accept handshake (bus_req/bus_ready) plus a separate read-data
// return (bus_rvalid/bus_rdata); stores never return data.
`timescale 1ns/1ps
interface hart_seq_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_ready, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_ready, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/hart_seq.sv
// Multi-cycle sequencer around the single-cycle hart core. Owns the PC and the
// latched instruction, shares one bus port between fetch and load/store, does
// store lane steering and load alignment/extension, and emits a one-cycle
// commit pulse that qualifies the hart's register-file write.
`timescale 1ns/1ps
module hart_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic [31:0]       pc,
   output logic [31:0]       insn,
   input  logic [31:0]       nextpc,
   input  logic [31:0]       memaddr,
   input  logic [31:0]       memwdata,
   input  logic              memw,
   input  logic              memr,
   input  logic              memsext,
   input  logic [1:0]        memwidth,
   output logic [31:0]       memrdata,
   output logic              hart_commit,
   hart_seq_if.master        bus,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic [31:0]       fault_pc
);

   typedef enum logic [2:0] {
      S_IFETCH, S_IWAIT, S_EXEC, S_DREQ, S_DWAIT, S_COMMIT, S_FAULT
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_insn;
   logic [31:0] r_memrdata;
   logic        r_commit;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [3:0]  r_bus_be;
   logic        r_fault;
   logic [1:0]  r_fault_cause;
   logic [31:0] r_fault_pc;
   // Access attributes captured in EXEC so the load path does not depend on
   // the hart's combinational outputs staying put through the data phase.
   logic [1:0]  r_lane;
   logic [1:0]  r_width;
   logic        r_sext;
   logic        r_store;

   logic        w_mem;
   logic        w_misal;
   logic [1:0]  w_cause;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_shift;
   logic [31:0] w_ld_data;

   assign w_mem   = memr | memw;
   assign w_misal = ((memwidth == 2'd1) && memaddr[0]) ||
                    ((memwidth == 2'd2) && (memaddr[1:0] != 2'b00));

   // Fault classification in priority order; 00 means the instruction is clean.
   always_comb begin
      w_cause = 2'b00;
      if (w_mem && (memwidth == 2'd3))
         w_cause = 2'b11;
      else if (w_mem && w_misal)
         w_cause = 2'b01;
      else if (nextpc[1:0] != 2'b00)
         w_cause = 2'b10;
   end

   // Store lane steering: replicate the datum across the word, enable its lanes.
   always_comb begin
      w_st_be    = 4'hF;
      w_st_wdata = memwdata;
      case (memwidth)
         2'd0: begin
            w_st_be    = 4'b0001 << memaddr[1:0];
            w_st_wdata = {4{memwdata[7:0]}};
         end
         2'd1: begin
            w_st_be    = 4'b0011 << memaddr[1:0];
            w_st_wdata = {2{memwdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load alignment: shift the addressed byte to bit 0, then truncate and extend.
   assign w_ld_shift = bus.bus_rdata >> {r_lane, 3'b000};

   always_comb begin
      case (r_width)
         2'd0:    w_ld_data = {{24{r_sext & w_ld_shift[7]}},  w_ld_shift[7:0]};
         2'd1:    w_ld_data = {{16{r_sext & w_ld_shift[15]}}, w_ld_shift[15:0]};
         default: w_ld_data = w_ld_shift;
      endcase
   end

   // Sequencer FSM; all bus and hart-facing outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IFETCH;
         r_pc          <= RESET_PC;
         r_insn        <= NOP;
         r_memrdata    <= 32'h0;
         r_commit      <= 1'b0;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_addr    <= {RESET_PC[31:2], 2'b00};
         r_bus_wdata   <= 32'h0;
         r_bus_be      <= 4'h0;
         r_fault       <= 1'b0;
         r_fault_cause <= 2'b00;
         r_fault_pc    <= 32'h0;
         r_lane        <= 2'b00;
         r_width       <= 2'b00;
         r_sext        <= 1'b0;
         r_store       <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         case (r_state)
            S_IFETCH: begin
               // Coming out of reset the request is not yet raised; raise it
               // here. From COMMIT it is raised on entry, so no cycle is lost.
               if (!r_bus_req) begin
                  r_bus_req  <= 1'b1;
                  r_bus_we   <= 1'b0;
                  r_bus_be   <= 4'hF;
                  r_bus_addr <= {r_pc[31:2], 2'b00};
               end else if (bus.bus_ready) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_IWAIT;
               end
            end
            S_IWAIT: begin
               if (bus.bus_rvalid) begin
                  r_insn  <= bus.bus_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_lane  <= memaddr[1:0];
               r_width <= memwidth;
               r_sext  <= memsext;
               r_store <= memw;
               if (w_cause != 2'b00) begin
                  r_state       <= S_FAULT;
                  r_fault       <= 1'b1;
                  r_fault_cause <= w_cause;
                  r_fault_pc    <= r_pc;
               end else if (w_mem) begin
                  // memr together with memw is handled as a store.
                  r_state     <= S_DREQ;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= memw;
                  r_bus_addr  <= {memaddr[31:2], 2'b00};
                  r_bus_be    <= memw ? w_st_be : 4'hF;
                  r_bus_wdata <= memw ? w_st_wdata : 32'h0;
               end else begin
                  r_state  <= S_COMMIT;
                  r_commit <= 1'b1;
               end
            end
            S_DREQ: begin
               if (bus.bus_ready) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  if (r_store) begin
                     r_state  <= S_COMMIT;
                     r_commit <= 1'b1;
                  end else begin
                     r_state <= S_DWAIT;
                  end
               end
            end
            S_DWAIT: begin
               if (bus.bus_rvalid) begin
                  r_memrdata <= w_ld_data;
                  r_state    <= S_COMMIT;
                  r_commit   <= 1'b1;
               end
            end
            S_COMMIT: begin
               r_pc       <= nextpc;
               r_state    <= S_IFETCH;
               r_bus_req  <= 1'b1;
               r_bus_we   <= 1'b0;
               r_bus_be   <= 4'hF;
               r_bus_addr <= {nextpc[31:2], 2'b00};
            end
            S_FAULT: ;
            default: r_state <= S_IFETCH;
         endcase
      end
   end

   assign pc            = r_pc;
   assign insn          = r_insn;
   assign memrdata      = r_memrdata;
   assign hart_commit   = r_commit;
   assign fault         = r_fault;
   assign fault_cause   = r_fault_cause;
   assign fault_pc      = r_fault_pc;
   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_wdata = r_bus_wdata;
   assign bus.bus_be    = r_bus_be;

endmodule

// File: tb/tb_hart_seq.sv
// Bench for hart_seq: the bench plays both the hart (driving memr/memw/addr/
// nextpc) and a memory with programmable ready stall and rvalid delay. A
// reference model derives bus transactions, latency, load data and fault
// outcome from the access rules with plain arithmetic.
`timescale 1ns/1ps
module tb_hart_seq;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] pc, insn, nextpc, memaddr, memwdata, memrdata, fault_pc;
   logic        memw, memr, memsext, hart_commit, fault;
   logic [1:0]  memwidth, fault_cause;

   hart_seq_if bif();

   hart_seq #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .pc(pc), .insn(insn), .nextpc(nextpc),
      .memaddr(memaddr), .memwdata(memwdata), .memw(memw), .memr(memr),
      .memsext(memsext), .memwidth(memwidth), .memrdata(memrdata),
      .hart_commit(hart_commit), .bus(bif), .fault(fault),
      .fault_cause(fault_cause), .fault_pc(fault_pc)
   );

   int checks;
   int errors;
   int ready_stall;
   int rvalid_dly;
   logic [31:0] model_pc;
   logic [31:0] model_rdata;
   logic [31:0] mem [logic [29:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'h5A5A_0013;
   endfunction

   function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = mem_rd(a);
      for (int k = 0; k < 4; k++)
         if (be[k]) w[8*k +: 8] = d[8*k +: 8];
      mem[a[31:2]] = w;
   endfunction

   // Memory responder: decides ready/rvalid at each falling edge.
   initial begin
      int          stall_cnt;
      int          pend_cnt;
      bit          pend;
      logic [31:0] pend_data;
      stall_cnt = 0; pend_cnt = 0; pend = 0; pend_data = 0;
      bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h0;
      forever begin
         @(negedge clk);
         bif.bus_rvalid = 1'b0;
         bif.bus_rdata  = $urandom;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
               bif.bus_rvalid = 1'b1;
               bif.bus_rdata  = pend_data;
               pend = 0;
            end
         end
         bif.bus_ready = 1'b0;
         if (bif.bus_req === 1'b1) begin
            if (stall_cnt < ready_stall) begin
               stall_cnt++;
            end else begin
               bif.bus_ready = 1'b1;
               stall_cnt = 0;
               if (bif.bus_we) begin
                  mem_wr(bif.bus_addr, bif.bus_wdata, bif.bus_be);
               end else begin
                  pend = 1; pend_cnt = rvalid_dly; pend_data = mem_rd(bif.bus_addr);
               end
            end
         end else begin
            stall_cnt = 0;
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Runs one instruction with the given hart-side behaviour and checks it.
   task automatic run_insn(input string tag, input bit is_r, input bit is_w,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input bit sext,
                           input logic [31:0] npc, input int stall, input int dly);
      logic [31:0] exp_word, exp_rdata, exp_wdata, mask, ins_seen, mrd_seen;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  exp_be, s_be;
      logic        s_we;
      logic [1:0]  exp_cause;
      bit          s_valid, seen_req, done, is_mem;
      int          start_cyc, commit_cyc, ncommit, unstable, exp_lat, exp_ntx;
      int          nbytes, off, lat, late_act;
      logic [31:0] tx_addr[$];
      logic        tx_we[$];
      logic [3:0]  tx_be[$];
      logic [31:0] tx_wdata[$];

      @(posedge clk); #1;
      memr = is_r; memw = is_w; memaddr = addr; memwdata = wdata;
      memwidth = width; memsext = sext; nextpc = npc;
      ready_stall = stall; rvalid_dly = dly;

      checks++;
      if (pc !== model_pc) begin
         errors++; $display("FAIL %s pc_before got=%08h exp=%08h", tag, pc, model_pc);
      end

      // Reference model
      is_mem = is_r || is_w;
      off    = int'(addr[1:0]);
      nbytes = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
      exp_cause = 2'd0;
      if (is_mem && width == 2'd3)          exp_cause = 2'd3;
      else if (is_mem && (off % nbytes) != 0) exp_cause = 2'd1;
      else if (npc[1:0] != 2'b00)           exp_cause = 2'd2;
      exp_be = 4'h0; exp_wdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         exp_wdata[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
         if (k >= off && k < off + nbytes) exp_be[k] = 1'b1;
      end
      if (!is_w) exp_be = 4'hF;
      exp_word  = mem_rd(addr);
      exp_rdata = model_rdata;
      if (is_r && !is_w) begin
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nbytes)) - 32'h1);
         exp_rdata = (exp_word >> (8*off)) & mask;
         if (sext && exp_rdata[8*nbytes-1]) exp_rdata = exp_rdata | ~mask;
      end
      exp_lat = (stall + 1 + dly) + 1 + 1;
      if (is_mem) exp_lat = exp_lat + stall + 1 + (is_w ? 0 : dly);
      exp_ntx = (is_mem && exp_cause == 2'd0) ? 2 : 1;

      s_valid = 0; seen_req = 0; done = 0; start_cyc = 0; commit_cyc = 0;
      ncommit = 0; unstable = 0; ins_seen = 0; mrd_seen = 0;
      s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk); #1;
         if (bif.bus_req) begin
            if (!seen_req) begin seen_req = 1; start_cyc = cyc; end
            if (!s_valid) begin
               s_valid = 1; s_addr = bif.bus_addr; s_we = bif.bus_we;
               s_be = bif.bus_be; s_wdata = bif.bus_wdata;
            end else if ({s_addr, s_we, s_be, s_wdata} !==
                         {bif.bus_addr, bif.bus_we, bif.bus_be, bif.bus_wdata}) begin
               unstable++;
            end
            if (bif.bus_ready) begin
               tx_addr.push_back(s_addr); tx_we.push_back(s_we);
               tx_be.push_back(s_be); tx_wdata.push_back(s_wdata);
               s_valid = 0;
            end
         end
         if (hart_commit) begin
            ncommit++; commit_cyc = cyc; ins_seen = insn; mrd_seen = memrdata; done = 1;
         end
         if (fault) done = 1;
      end
      lat = commit_cyc - start_cyc + 1;

      checks++;
      if (!done) begin errors++; $display("FAIL %s timeout got=none exp=commit_or_fault", tag); end
      checks++;
      if (tx_addr.size() !== exp_ntx) begin
         errors++; $display("FAIL %s ntx got=%0d exp=%0d", tag, tx_addr.size(), exp_ntx);
      end
      checks++;
      if (tx_addr.size() == 0 || tx_addr[0] !== {model_pc[31:2], 2'b00} ||
          tx_we[0] !== 1'b0 || tx_be[0] !== 4'hF) begin
         errors++;
         $display("FAIL %s fetch got=addr %08h we %b be %h exp=addr %08h we 0 be f",
                  tag, (tx_addr.size() > 0) ? tx_addr[0] : 32'hx,
                  (tx_we.size() > 0) ? tx_we[0] : 1'bx,
                  (tx_be.size() > 0) ? tx_be[0] : 4'hx, model_pc);
      end
      checks++;
      if (unstable !== 0) begin errors++; $display("FAIL %s stable got=%0d exp=0", tag, unstable); end

      if (exp_cause == 2'd0) begin
         if (exp_ntx == 2 && tx_addr.size() >= 2) begin
            checks++;
            if (tx_addr[1] !== {addr[31:2], 2'b00} || tx_we[1] !== is_w || tx_be[1] !== exp_be) begin
               errors++;
               $display("FAIL %s data_req got=addr %08h we %b be %b exp=addr %08h we %b be %b",
                        tag, tx_addr[1], tx_we[1], tx_be[1], {addr[31:2], 2'b00}, is_w, exp_be);
            end
            if (is_w) begin
               checks++;
               if (tx_wdata[1] !== exp_wdata) begin
                  errors++; $display("FAIL %s wdata got=%08h exp=%08h", tag, tx_wdata[1], exp_wdata);
               end
            end
         end
         checks++;
         if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat); end
         checks++;
         if (ncommit !== 1) begin errors++; $display("FAIL %s commits got=%0d exp=1", tag, ncommit); end
         checks++;
         if (ins_seen !== mem_rd(model_pc)) begin
            errors++; $display("FAIL %s insn got=%08h exp=%08h", tag, ins_seen, mem_rd(model_pc));
         end
         checks++;
         if (mrd_seen !== exp_rdata) begin
            errors++; $display("FAIL %s memrdata got=%08h exp=%08h", tag, mrd_seen, exp_rdata);
         end
         $display("INSN %-8s pc=%08h r=%0d w=%0d addr=%08h width=%0d lat=%0d memrdata=%08h",
                  tag, model_pc, is_r, is_w, addr, width, lat, mrd_seen);
         model_pc    = npc;
         model_rdata = exp_rdata;
      end else begin
         checks++;
         if (fault !== 1'b1 || fault_cause !== exp_cause || fault_pc !== model_pc) begin
            errors++;
            $display("FAIL %s fault got=%b cause %0d pc %08h exp=1 cause %0d pc %08h",
                     tag, fault, fault_cause, fault_pc, exp_cause, model_pc);
         end
         late_act = ncommit;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (bif.bus_req !== 1'b0 || hart_commit !== 1'b0 || fault !== 1'b1) late_act++;
         end
         checks++;
         if (late_act !== 0) begin
            errors++; $display("FAIL %s fault_quiet got=%0d exp=0", tag, late_act);
         end
         $display("INSN %-8s pc=%08h r=%0d w=%0d addr=%08h width=%0d fault_cause=%0d",
                  tag, model_pc, is_r, is_w, addr, width, fault_cause);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      checks++;
      if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%08h exp=%08h", pc, RESET_PC); end
      checks++;
      if (insn !== 32'h0000_0013) begin errors++; $display("FAIL reset_insn got=%08h exp=00000013", insn); end
      checks++;
      if (memrdata !== 32'h0) begin errors++; $display("FAIL reset_memrdata got=%08h exp=0", memrdata); end
      checks++;
      if ({bif.bus_req, bif.bus_we, bif.bus_be, hart_commit, fault, fault_cause, fault_pc} !== 42'h0) begin
         errors++;
         $display("FAIL reset_ctrl got=req %b we %b be %h commit %b fault %b cause %0d fpc %08h exp=all 0",
                  bif.bus_req, bif.bus_we, bif.bus_be, hart_commit, fault, fault_cause, fault_pc);
      end
      reset = 1'b0;
      model_pc = RESET_PC; model_rdata = 32'h0;
   endtask

   task automatic test_alu();
      mem[30'h0] = 32'h0050_0093;
      run_insn("addi", 0, 0, 32'h0, 32'h0, 2'd2, 0, model_pc + 32'd4, 0, 1);
   endtask

   task automatic test_store();
      run_insn("sb", 0, 1, 32'h0000_0103, 32'h0000_00AB, 2'd0, 0, model_pc + 32'd4, 0, 1);
      run_insn("sh", 0, 1, 32'h0000_0112, 32'h1234_5678, 2'd1, 0, model_pc + 32'd4, 0, 1);
      run_insn("sw", 0, 1, 32'h0000_0118, 32'hCAFE_F00D, 2'd2, 0, model_pc + 32'd4, 0, 1);
   endtask

   task automatic test_load();
      mem[30'h40] = 32'h1280_FF00;
      run_insn("lb", 1, 0, 32'h0000_0102, 32'h0, 2'd0, 1, model_pc + 32'd4, 0, 1);
      run_insn("lbu", 1, 0, 32'h0000_0102, 32'h0, 2'd0, 0, model_pc + 32'd4, 0, 1);
      run_insn("lh", 1, 0, 32'h0000_0100, 32'h0, 2'd1, 1, model_pc + 32'd4, 0, 1);
   endtask

   task automatic test_stall();
      mem[30'h41] = 32'h8765_4321;
      run_insn("lw_stl", 1, 0, 32'h0000_0104, 32'h0, 2'd2, 1, model_pc + 32'd4, 3, 2);
      run_insn("sw_stl", 1, 1, 32'h0000_0108, 32'h0BAD_BEEF, 2'd2, 0, model_pc + 32'd4, 3, 2);
   endtask

   task automatic test_fault();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: run_insn("f_misal", 1, 0, 32'h0000_0102, 32'h0, 2'd2, 0, model_pc + 32'd4, 0, 1);
            1: run_insn("f_width", 0, 1, 32'h0000_0101, 32'h55, 2'd3, 0, model_pc + 32'd4, 1, 1);
            2: run_insn("f_npc", 0, 0, 32'h0, 32'h0, 2'd0, 0, model_pc + 32'd6, 0, 2);
            default: run_insn("f_prio", 1, 0, 32'h0000_1001, 32'h0, 2'd1, 1, model_pc + 32'd2, 2, 1);
         endcase
         do_reset(2);
         checks++;
         if (fault !== 1'b0 || fault_cause !== 2'b00 || fault_pc !== 32'h0 || pc !== RESET_PC) begin
            errors++;
            $display("FAIL fault_clear got=fault %b cause %0d fpc %08h pc %08h exp=0 0 0 %08h",
                     fault, fault_cause, fault_pc, pc, RESET_PC);
         end
         reset = 1'b0;
         model_pc = RESET_PC; model_rdata = 32'h0;
         run_insn("f_after", 0, 0, 32'h0, 32'h0, 2'd0, 0, 32'd4, 0, 1);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 0;
      mem[30'h800] = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      memr = 1; memw = 0; memaddr = 32'h0000_2000; memwidth = 2'd2; memsext = 0;
      nextpc = model_pc + 32'd4; ready_stall = 0; rvalid_dly = 4;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk); #1;
         if (bif.bus_req && bif.bus_ready && !bif.bus_we && bif.bus_addr == 32'h0000_2000) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midrst_dreq got=none exp=load_request"); end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (pc !== RESET_PC || insn !== 32'h0000_0013 || memrdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_state got=pc %08h insn %08h memrdata %08h exp=%08h 00000013 0",
                  pc, insn, memrdata, RESET_PC);
      end
      model_pc = RESET_PC; model_rdata = 32'h0;
      run_insn("mr_after", 0, 0, 32'h0, 32'h0, 2'd0, 0, 32'd8, 0, 1);
   endtask

   task automatic test_random();
      int          kind, stall, dly;
      logic [1:0]  width;
      logic [31:0] addr, npc;
      for (int i = 0; i < 30; i++) begin
         kind  = $urandom_range(0, 3);
         width = 2'($urandom_range(0, 2));
         stall = $urandom_range(0, 3);
         dly   = $urandom_range(1, 3);
         addr  = 32'h0000_1000 + ($urandom_range(0, 63) << 2);
         if (width == 2'd0) addr[1:0] = 2'($urandom_range(0, 3));
         else if (width == 2'd1) addr[1] = 1'($urandom_range(0, 1));
         npc = ($urandom_range(0, 1) == 1) ? model_pc + 32'd4 : 32'($urandom_range(0, 255) << 2);
         case (kind)
            0: run_insn("r_alu", 0, 0, addr, $urandom, width, 1'($urandom_range(0, 1)), npc, stall, dly);
            1: run_insn("r_st", 0, 1, addr, $urandom, width, 0, npc, stall, dly);
            2: run_insn("r_ld", 1, 0, addr, 32'h0, width, 1'($urandom_range(0, 1)), npc, stall, dly);
            default: run_insn("r_rw", 1, 1, addr, $urandom, width, 0, npc, stall, dly);
         endcase
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1; memr = 0; memw = 0; memsext = 0; memwidth = 2'd0;
      memaddr = 0; memwdata = 0; nextpc = 0;
      ready_stall = 0; rvalid_dly = 1;
      model_pc = RESET_PC; model_rdata = 32'h0;
      test_reset();
      test_alu();
      test_store();
      test_load();
      test_stall();
      test_fault();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
